// File: rtl/serial_rx_fifo.sv
// Serial flit receiver: head-bit framed, LSB-first deserialiser with optional even parity,
// feeding a DEPTH-entry first-word-fall-through FIFO.
module serial_rx_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter bit PARITY_EN = 0,
   parameter int routerid  = -1,
   parameter     port      = "unknown"
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       serial_in,
   input  logic                       item_read,
   output logic                       valid,
   output logic [WIDTH-1:0]           parallel_out,
   output logic                       channel_busy,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       parity_err,
   output logic [7:0]                 err_count
);
   localparam int CW = $clog2(WIDTH);
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

   typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;

   state_t           state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop, full, last_bit, par_ok;
   logic [WIDTH-1:0] push_data;

   always_comb begin
      last_bit = (state == RECV) && (bit_cnt == LAST);
      par_ok   = ~(^{shift_reg, serial_in});
      // Without parity the flit is pushed on the same edge its last bit is sampled.
      if (PARITY_EN) begin
         push_data = shift_reg;
         push      = (state == PAR) && par_ok;
      end else begin
         push_data = {serial_in, shift_reg[WIDTH-2:0]};
         push      = last_bit;
      end
   end

   assign full         = (count == NW'(DEPTH));
   assign valid        = (count != '0);
   assign pop          = item_read & valid;
   assign channel_busy = (state != IDLE) | full;
   assign parallel_out = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         parity_err <= 1'b0;
         err_count  <= '0;
      end else begin
         parity_err <= 1'b0;
         case (state)
            IDLE: if (serial_in && !full) begin
               state   <= RECV;
               bit_cnt <= '0;
            end
            RECV: begin
               shift_reg[bit_cnt] <= serial_in;
               bit_cnt            <= bit_cnt + 1'b1;
               if (bit_cnt == LAST) state <= PARITY_EN ? PAR : IDLE;
            end
            PAR: begin
               state <= IDLE;
               if (!par_ok) begin
                  parity_err <= 1'b1;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase

         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         // A push onto an empty FIFO never coincides with a pop, since pop needs valid.
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && push && routerid > -1)
         $display("router %0d port %s push %h", routerid, port, push_data);
   end
`endif

endmodule

// File: doc/serial_rx_fifo.md
Name: serial_rx_fifo

Overview:
- Parametrised single-clock successor of the per-port serial flit receiver, used at router input ports.
- Deserialises head-bit-framed serial flits of configurable width, LSB first.
- Optionally checks an even-parity bit.
- Buffers received flits in a DEPTH-entry first-word-fall-through FIFO, so the sender can stream back-to-back flits while the router drains them.

Parameters:
- WIDTH, 16, flit width in bits (payload+address); >=2.
- DEPTH, 4, FIFO entries; power of two, >=2.
- PARITY_EN, 0, 1 = one even-parity bit follows the data bits.
- routerid, -1, router index (debug only).
- port, "unknown", port name (debug only).

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high.
- serial_in  input  1  serial line; idle low.
- item_read  input  1  consumer pops head entry this cycle (honoured only when valid).
- valid  output  1  FIFO non-empty.
- parallel_out  output  WIDTH  head FIFO entry; FWFT, stable while valid and no pop.
- channel_busy  output  1  sender must not start a flit.
- count  output  clog2(DEPTH+1)  FIFO occupancy.
- parity_err  output  1  one-cycle pulse on a dropped flit.
- err_count  output  8  dropped-flit count; saturates at 255.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, FIFO empty, count=0, valid=0, parallel_out=0, channel_busy=0, parity_err=0, err_count=0.
  - Reset mid-frame abandons the partial flit; no push, no error.
- Frame format: head bit (1), then WIDTH data bits (bit0 first), then the parity bit if PARITY_EN.
  - Even parity: XOR of data bits and parity bit must equal 0.
- FSM states: IDLE, RECV, PAR.
  - IDLE: if serial_in=1 and FIFO not full -> RECV, bit_cnt=0. If serial_in=1 and FIFO full, the bit is ignored (sender protocol violation) and state stays IDLE.
  - RECV: shift_reg[bit_cnt] <= serial_in, bit_cnt++ each cycle. After bit WIDTH-1 is sampled:
    - PARITY_EN=0: push {shift_reg with final bit} and go to IDLE.
    - PARITY_EN=1: go to PAR.
  - PAR: sample the parity bit.
    - Good parity: push and go to IDLE.
    - Bad parity: drop the flit, parity_err=1 for exactly one cycle, err_count++ (saturating at 255), go to IDLE.
- Back-to-back frames: the IDLE state may sample the next head bit in the cycle right after the last data/parity bit (zero gap).
- Latency, head bit sampled at edge t:
  - Data bits are sampled at edges t+1..t+WIDTH.
  - Push at edge t+WIDTH (+1 if PARITY_EN).
  - valid rises after that edge if the FIFO was empty.
- channel_busy = (state != IDLE) | (count == DEPTH).
  - The FIFO cannot overflow: a frame is only started when at least one slot is free, and count cannot rise mid-frame.
- FIFO:
  - Pop when item_read & valid; item_read with valid=0 is ignored.
  - Simultaneous push and pop: count unchanged. If the FIFO was empty, the push takes effect and the pop is ignored (valid=0 that cycle).
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count = pushes - pops; never exceeds DEPTH, never goes below 0.
  - parallel_out = mem[rd_ptr] when valid, else 0.
- Simulation only: when routerid > -1, $display router, port and data on each push.

Test Plan:
- Single flit, WIDTH=8, PARITY_EN=0: serial head=1 then 0xA5 LSB first from edge t -> channel_busy=1 at edges t+1..t+8, valid=1 and parallel_out=0xA5 after edge t+8, count=1; item_read -> valid=0, count=0.
- Back-to-back fill, DEPTH=4, no reads: 5 flits 0x01..0x05 sent with zero gap -> after 4 pushes count=4 and channel_busy=1; 5th head bit ignored; pops return 0x01..0x04 in order; pointers wrap correctly on a subsequent refill.
- Parity, PARITY_EN=1: 0x03 with parity 0 -> pushed. 0x03 with parity 1 -> not pushed, parity_err pulses 1 cycle, err_count=1. 300 bad flits -> err_count=255.
- Simultaneous push/pop: count=2 and item_read asserted at the same edge as a push -> count stays 2, order preserved. Same on an empty FIFO -> count=1, head = new flit.
- Reset mid-frame: reset asserted after 3 data bits -> all outputs at reset values next cycle; a following clean flit 0x5A is received correctly.
- Idle noise: serial_in=0 for 100 cycles -> no push, valid=0, channel_busy=0.
